// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the NTT job scheduler.
package ntt_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_READ,
    S_RESP
  } state_e;

  localparam int unsigned NUM_MODULI    = 40;
  localparam int unsigned DEF_MEM_DELAY = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr_i and wraps; the grant is one-hot or zero.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Grants NTT jobs to requesters by round-robin and sequences the core through
// load, start, run, read-back and response.
module ntt_job_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned MEM_DELAY = DEF_MEM_DELAY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [6*NUM_REQ-1:0]       req_mod_idx,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       rsp_ready,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_err,
  output logic [$clog2(NUM_REQ)-1:0] core_sel,
  output logic                       core_mem_write,
  output logic                       core_mem_read,
  output logic                       core_start,
  output logic [5:0]                 core_mod_idx,
  input  logic                       core_done,
  output logic                       busy
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (TIMEOUT > MEM_DELAY) ? TIMEOUT : MEM_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [5:0]        mod_q, mod_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gidx;
  logic [5:0]         gmod;
  logic               grant_en;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    gidx = '0;
    gmod = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gidx = ID_W'(i);
        gmod = req_mod_idx[i*6 +: 6];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    mod_d    = mod_q;
    err_d    = err_q;
    grant_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_en = 1'b1;
          id_d     = gidx;
          mod_d    = gmod;
          ptr_d    = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          cnt_d    = '0;
          if (gmod >= 6'(NUM_MODULI)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done is blind in the first RUN cycle and takes priority over timeout
        if (cnt_q != '0 && core_done) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_W'(MEM_DELAY - 1)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      mod_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      mod_q   <= mod_d;
      err_q   <= err_d;
    end
  end

  // The grant is combinational in IDLE, so it is masked while reset is held.
  assign req_ready      = gnt & {NUM_REQ{grant_en & reset}};
  assign core_sel       = id_q;
  assign core_mod_idx   = mod_q;
  assign core_mem_write = (state_q == S_LOAD);
  assign core_start     = (state_q == S_START);
  assign core_mem_read  = (state_q == S_READ) || ((state_q == S_RESP) && !err_q);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_id         = id_q;
  assign rsp_err        = err_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed bench for ntt_job_scheduler (NUM_REQ=2, TIMEOUT=16, MEM_DELAY=2).
module tb_ntt_job_scheduler;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [11:0] req_mod_idx;
  logic [1:0]  req_ready;
  logic        rsp_ready;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic        rsp_err;
  logic [0:0]  core_sel;
  logic        core_mem_write;
  logic        core_mem_read;
  logic        core_start;
  logic [5:0]  core_mod_idx;
  logic        core_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ntt_job_scheduler #(
    .NUM_REQ   (2),
    .TIMEOUT   (16),
    .MEM_DELAY (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_mod_idx    (req_mod_idx),
    .req_ready      (req_ready),
    .rsp_ready      (rsp_ready),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_err        (rsp_err),
    .core_sel       (core_sel),
    .core_mem_write (core_mem_write),
    .core_mem_read  (core_mem_read),
    .core_start     (core_start),
    .core_mod_idx   (core_mod_idx),
    .core_done      (core_done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected end before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle into IDLE with the requests already driven (cycle 0).
  // Leaves the bench in the RESP cycle (done_cyc + 3).
  task automatic do_job(input string tag, input logic [1:0] exp_rdy, input logic [5:0] exp_mod,
                        input logic exp_id, input int done_cyc, input bit ghost,
                        input logic [1:0] rv_after);
    #1;
    check({tag, ".c0.ready"}, 32'(req_ready), 32'(exp_rdy));
    check({tag, ".c0.busy"}, 32'(busy), 32'd0);
    tick();
    req_valid = rv_after;
    #1;
    check({tag, ".c1.wr"}, 32'(core_mem_write), 32'd1);
    check({tag, ".c1.sel"}, 32'(core_sel), 32'(exp_id));
    check({tag, ".c1.ready"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, ".c2.start"}, 32'(core_start), 32'd1);
    check({tag, ".c2.mod"}, 32'(core_mod_idx), 32'(exp_mod));
    check({tag, ".c2.wr"}, 32'(core_mem_write), 32'd0);
    tick();
    if (ghost) core_done = 1'b1;
    #1;
    check({tag, ".c3.start"}, 32'(core_start), 32'd0);
    for (int c = 4; c <= done_cyc; c++) begin
      tick();
      core_done = (c == done_cyc);
      #1;
      if (ghost && c == 4) check({tag, ".ghost.rd"}, 32'(core_mem_read), 32'd0);
    end
    check({tag, ".done.rd"}, 32'(core_mem_read), 32'd0);
    tick();
    core_done = 1'b0;
    #1;
    check({tag, ".read1.rd"}, 32'(core_mem_read), 32'd1);
    check({tag, ".read1.vld"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, ".read2.rd"}, 32'(core_mem_read), 32'd1);
    check({tag, ".read2.vld"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, ".resp.vld"}, 32'(rsp_valid), 32'd1);
    check({tag, ".resp.id"}, 32'(rsp_id), 32'(exp_id));
    check({tag, ".resp.err"}, 32'(rsp_err), 32'd0);
    check({tag, ".resp.rd"}, 32'(core_mem_read), 32'd1);
    check({tag, ".resp.ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_mod_idx = '0;
    rsp_ready   = 1'b0;
    core_done   = 1'b0;

    // reset state
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.vld", 32'(rsp_valid), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.core", {28'd0, core_mem_write, core_mem_read, core_start, core_sel}, 32'd0);
    check("rst.mod", 32'(core_mod_idx), 32'd0);
    tick();
    reset = 1'b1;

    // Scenario 1: single job on requester 0, done at cycle 10 -> response at 13
    tick();
    req_valid   = 2'b01;
    req_mod_idx = {6'd0, 6'd5};
    rsp_ready   = 1'b1;
    do_job("s1", 2'b01, 6'd5, 1'b0, 10, 1'b0, 2'b00);
    tick();
    check("s1.idle.vld", 32'(rsp_valid), 32'd0);
    check("s1.idle.busy", 32'(busy), 32'd0);

    // Scenario 3: mod_idx 40 on requester 1 -> error response at cycle 1, no core pulses
    tick();
    req_valid   = 2'b10;
    req_mod_idx = {6'd40, 6'd0};
    rsp_ready   = 1'b0;
    #1;
    check("s3.c0.ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check("s3.c1.vld", 32'(rsp_valid), 32'd1);
    check("s3.c1.err", 32'(rsp_err), 32'd1);
    check("s3.c1.id", 32'(rsp_id), 32'd1);
    check("s3.c1.core", {29'd0, core_mem_write, core_mem_read, core_start}, 32'd0);
    tick();
    check("s3.c2.core", {29'd0, core_mem_write, core_mem_read, core_start}, 32'd0);
    check("s3.c2.vld", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    check("s3.c3.vld", 32'(rsp_valid), 32'd0);
    check("s3.c3.busy", 32'(busy), 32'd0);

    // Scenario 2: both requesting for three jobs -> grants 0,1,0; mod 39 is legal
    req_valid   = 2'b11;
    req_mod_idx = {6'd39, 6'd7};
    do_job("s2a", 2'b01, 6'd7, 1'b0, 5, 1'b1, 2'b11);
    tick();
    do_job("s2b", 2'b10, 6'd39, 1'b1, 4, 1'b0, 2'b11);
    tick();
    do_job("s2c", 2'b01, 6'd7, 1'b0, 6, 1'b0, 2'b00);
    tick();
    check("s2.idle.busy", 32'(busy), 32'd0);

    // Scenario 4a: no done -> 16 RUN cycles (3..18), error response at 19
    req_valid   = 2'b01;
    req_mod_idx = {6'd0, 6'd3};
    #1;
    check("s4a.c0.ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    for (int c = 2; c <= 18; c++) tick();
    check("s4a.c18.vld", 32'(rsp_valid), 32'd0);
    check("s4a.c18.busy", 32'(busy), 32'd1);
    tick();
    check("s4a.c19.vld", 32'(rsp_valid), 32'd1);
    check("s4a.c19.err", 32'(rsp_err), 32'd1);
    check("s4a.c19.rd", 32'(core_mem_read), 32'd0);
    tick();
    check("s4a.idle.busy", 32'(busy), 32'd0);

    // Scenario 4b: done on the last RUN cycle (count 15) wins over timeout
    req_valid = 2'b01;
    do_job("s4b", 2'b01, 6'd3, 1'b0, 18, 1'b0, 2'b00);
    tick();

    // Scenario 5: response stalled for 5 cycles
    req_valid   = 2'b10;
    req_mod_idx = {6'd20, 6'd0};
    rsp_ready   = 1'b0;
    do_job("s5", 2'b10, 6'd20, 1'b1, 4, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s5.stall.vld", 32'(rsp_valid), 32'd1);
      check("s5.stall.meta", {30'd0, rsp_id, rsp_err}, 32'b10);
      check("s5.stall.rd", 32'(core_mem_read), 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("s5.hs.vld", 32'(rsp_valid), 32'd1);
    tick();
    check("s5.post.vld", 32'(rsp_valid), 32'd0);
    check("s5.post.busy", 32'(busy), 32'd0);
    check("s5.post.rd", 32'(core_mem_read), 32'd0);

    // Scenario 6: reset during RUN; afterwards requester 0 wins even though 1 would be next
    req_valid   = 2'b01;
    req_mod_idx = {6'd0, 6'd12};
    #1;
    check("s6.c0.ready", 32'(req_ready), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    check("s6.run.busy", 32'(busy), 32'd1);
    #2;
    reset     = 1'b0;
    req_valid = 2'b11;
    #1;
    check("s6.rst.busy", 32'(busy), 32'd0);
    check("s6.rst.ready", 32'(req_ready), 32'd0);
    check("s6.rst.mod", 32'(core_mod_idx), 32'd0);
    check("s6.rst.core", {28'd0, core_mem_write, core_mem_read, core_start, core_sel}, 32'd0);
    check("s6.rst.rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    do_job("s6", 2'b01, 6'd12, 1'b0, 4, 1'b0, 2'b00);
    tick();
    check("s6.idle.busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_job_scheduler.md
NTT_JOB_SCHEDULER -- requirements
Module: ntt_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning number of requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT, default 4096, meaning maximum RUN-state cycles before abort.
REQ-003 SHALL have parameter MEM_DELAY, default 2, meaning NTT memory read latency in cycles.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning per-requester job request.
REQ-007 SHALL have port req_mod_idx, input, 6*NUM_REQ, meaning per-requester modulus index.
REQ-008 SHALL have port req_ready, output, NUM_REQ, meaning one-hot job acceptance.
REQ-009 SHALL have port rsp_valid, input-side ready rsp_ready, and outputs rsp_valid (1), rsp_id (clog2(NUM_REQ), min 1) and rsp_err (1), meaning the job-completion channel.
REQ-010 SHALL have outputs core_sel (clog2(NUM_REQ)), core_mem_write, core_mem_read, core_start (1 each), core_mod_idx (6), meaning NTT core control and the external din/dout mux select.
REQ-011 SHALL have input core_done (1) and output busy (1).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, START, RUN, READ, RESP.
REQ-013 In IDLE, when any req_valid is high, SHALL grant one requester by round-robin, assert req_ready for that requester for exactly one cycle, and latch its mod_idx and id.
REQ-014 Round-robin SHALL start from the requester after the last granted one; pointer = 0 after reset; the pointer SHALL update only on grant.
REQ-015 If the latched mod_idx >= 40, SHALL go directly to RESP with rsp_err=1 and no core_* pulses.
REQ-016 Otherwise, LOAD SHALL last one cycle with core_mem_write=1, followed by START for one cycle with core_start=1.
REQ-017 core_sel and core_mod_idx SHALL hold the latched values from grant until return to IDLE.
REQ-018 RUN SHALL count cycles from 0 and ignore core_done in its first cycle.
REQ-019 From RUN, core_done=1 SHALL go to READ.
REQ-020 From RUN, reaching count TIMEOUT-1 without done SHALL go to RESP with rsp_err=1.
REQ-021 If done and timeout coincide, done SHALL win.
REQ-022 READ SHALL last MEM_DELAY cycles with core_mem_read=1.
REQ-023 In RESP, core_mem_read SHALL remain 1 (on the success path), rsp_valid=1, and rsp_id/rsp_err SHALL be stable until the rsp_ready handshake.
REQ-024 Leaving RESP to IDLE SHALL occur on rsp_valid & rsp_ready, with rsp_valid deasserting the next cycle.
REQ-025 No new grant SHALL occur in the cycle of RESP exit.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 req_valid changes outside IDLE SHALL be ignored; core_done outside RUN SHALL be ignored.
REQ-028 Nominal latency SHALL be grant cycle 0, LOAD 1, START 2, RUN from 3, and rsp_valid at done_cycle+1+MEM_DELAY.

Reset
REQ-029 Reset low SHALL immediately force IDLE and set all outputs to 0, including the round-robin pointer, counter and latched id/mod_idx, regardless of current state.
REQ-030 After reset deasserts, the first grant SHALL prefer requester 0.

Structure
REQ-031 Package ntt_sched_pkg SHALL hold the state enum, NUM_MODULI=40 and the default MEM_DELAY.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer, one-hot grant).

Verification
REQ-033 Scenario 1: req_valid=01, mod_idx=5, core_done pulsed at cycle 10 -> req_ready=01 at cycle 0, mem_write at 1, start at 2 with core_mod_idx=5, rsp_valid at 13 with id=0, err=0.
REQ-034 Scenario 2: req_valid=11 held for three jobs -> grants 0,1,0 in order.
REQ-035 Scenario 3: mod_idx=40 -> no core_* pulses, rsp_valid with err=1 at cycle 1.
REQ-036 Scenario 4: TIMEOUT=16, core_done never asserted -> rsp_err=1 after 16 RUN cycles; core_done asserted on cycle 15 instead -> err=0.
REQ-037 Scenario 5: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_id, rsp_err and core_mem_read all stable; IDLE one cycle after the handshake.
REQ-038 Scenario 6: reset asserted during RUN -> all outputs 0 asynchronously; next grant goes to requester 0.
